hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Pipeline stall/flush controller for the 5-stage MIPS core. Decides each cycle whether IF/ID holds, whether a bubble enters ID/EX, and whether IF/ID is squashed after a taken branch/jump. Sequences the multi-cycle mult/div unit with a busy FSM, and runs a stall watchdog. Sits beside the forwarding unit: it covers only the hazards that forwarding cannot resolve.

## Interface
- MD_LATENCY, 4: EX cycles the mult/div unit is busy after issue (≥1)
- STALL_MAX, 15: consecutive-stall limit before `hazard_err` (must be > MD_LATENCY + 1)
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- ifid_rs, ifid_rt  in  5 each  source registers of the instruction in ID
- ifid_uses_rt  in  1  ID instruction reads rt as a source
- ifid_is_branch  in  1  ID holds beq/bne (compared in ID)
- ifid_is_md  in  1  ID holds mult/div/mfhi/mflo
- idex_rd  in  5  destination register of EX instruction (already rd/rt-muxed)
- idex_regwr, idex_memrd  in  1 each  EX instruction writes a register / is a load
- exmem_rd  in  5  destination register of MEM instruction
- exmem_memrd  in  1  MEM instruction is a load
- ex_md_start  in  1  mult/div issuing in EX this cycle
- branch_taken, jump  in  1 each  ID redirect resolved this cycle
- pc_we, ifid_we  out  1 each  PC / IF-ID register write enable
- idex_flush  out  1  load ID/EX with a bubble
- ifid_flush  out  1  squash IF/ID (load nop)
- md_busy, md_done  out  1 each  mult/div running / result valid this cycle
- hazard_err  out  1  sticky fault flag
- stall_cnt  out  16  total stall cycles (perf)

## Operation
- Dependency match: source s matches dest d iff d≠0 and d==ifid_rs, or (ifid_uses_rt and d==ifid_rt).
- lu_stall: idex_memrd and match(idex_rd).
- br_stall: ifid_is_branch and ((idex_regwr and match(idex_rd)) or (exmem_memrd and match(exmem_rd))).
- md_stall: ifid_is_md and state==MD_BUSY.
- stall = lu_stall | br_stall | md_stall → pc_we=0, ifid_we=0, idex_flush=1.
- Redirect: redirect = (branch_taken|jump) and !stall → ifid_flush=1; pc_we stays 1. During a stall branch_taken/jump are ignored (branch not yet resolved).
- MD FSM states MD_IDLE, MD_BUSY, MD_DONE:
  - IDLE: ex_md_start → BUSY, counter=MD_LATENCY−1.
  - BUSY: counter decrements; at 0 → DONE. ex_md_start here → hazard_err set, start ignored.
  - DONE: md_done=1 for one cycle; ex_md_start → BUSY (reload), else → IDLE.
- md_busy = (state==MD_BUSY).
- Watchdog: run counter increments each stall cycle, clears on any non-stall cycle, saturates at STALL_MAX; reaching STALL_MAX sets hazard_err. hazard_err clears only on reset.
- stall_cnt increments on each stall cycle, saturates at 16'hFFFF.

## Timing
- Stall/flush outputs are combinational from inputs and registered state; same-cycle response, no latency.
- Load-use and branch stalls last exactly one cycle each when the upstream pipeline advances normally; load-feeding-branch yields two consecutive stall cycles (EX then MEM).
- ex_md_start sampled at edge ending cycle T: md_busy high cycles T+1..T+MD_LATENCY, md_done at T+MD_LATENCY+1.
- Reset (async, any time, including mid-BUSY): state=MD_IDLE, counters=0, hazard_err=0. With all inputs 0: pc_we=1, ifid_we=1, idex_flush=0, ifid_flush=0, md_busy=0, md_done=0, stall_cnt=0.
- Register $0 never creates a dependency.

## Configuration
- HAZARD_PERF_EN defined: stall_cnt implemented as above.
- Undefined: stall_cnt tied to 0, counter logic removed; watchdog and all control behaviour unchanged.

## Test plan
- Load r5 in EX, ID uses rs=5 → one cycle pc_we=0, ifid_we=0, idex_flush=1; next cycle (load in MEM, no EX match) all clear.
- beq rs=3 in ID, lw r3 in EX → two stall cycles, then branch_taken=1 → ifid_flush=1, pc_we=1, no stall.
- ex_md_start pulse with MD_LATENCY=4, mfhi held in ID → md_busy 4 cycles with stall, md_done 5th cycle with stall=0.
- ex_md_start in MD_DONE → md_done=1 that cycle, md_busy=1 next; ex_md_start during BUSY → hazard_err=1, busy length unchanged.
- idex_memrd=1, idex_rd=0, ifid_rs=0 → no stall; branch_taken=1 during lu_stall → ifid_flush=0.
- Hold lu_stall 15 cycles → hazard_err=1 on 15th; stall_cnt=15 (HAZARD_PERF_EN) or 0 (undefined); rst_n low mid-BUSY → all outputs at reset values immediately.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage MIPS core: load-use, branch-operand and
// mult/div hazards, redirect squash, stall watchdog. Define HAZARD_PERF_EN for stall_cnt.
module hazard_stall_ctrl #(
   parameter int MD_LATENCY = 4,
   parameter int STALL_MAX  = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  ifid_rs,
   input  logic [4:0]  ifid_rt,
   input  logic        ifid_uses_rt,
   input  logic        ifid_is_branch,
   input  logic        ifid_is_md,
   input  logic [4:0]  idex_rd,
   input  logic        idex_regwr,
   input  logic        idex_memrd,
   input  logic [4:0]  exmem_rd,
   input  logic        exmem_memrd,
   input  logic        ex_md_start,
   input  logic        branch_taken,
   input  logic        jump,
   output logic        pc_we,
   output logic        ifid_we,
   output logic        idex_flush,
   output logic        ifid_flush,
   output logic        md_busy,
   output logic        md_done,
   output logic        hazard_err,
   output logic [15:0] stall_cnt
);

   typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

   localparam int MD_CW  = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
   localparam int RUN_CW = $clog2(STALL_MAX + 1);
   localparam logic [MD_CW-1:0]  MD_RELOAD = MD_CW'(MD_LATENCY - 1);
   localparam logic [RUN_CW-1:0] RUN_MAX   = RUN_CW'(STALL_MAX);
   localparam logic [RUN_CW-1:0] RUN_LAST  = RUN_CW'(STALL_MAX - 1);

   md_state_t         state;
   logic [MD_CW-1:0]  md_cnt;
   logic [RUN_CW-1:0] run_cnt;
   logic              lu_stall, br_stall, md_stall, stall;
   logic              md_err, wd_hit;

   // $0 is hardwired, so a zero destination never feeds a consumer.
   function automatic logic dep_match(input logic [4:0] d, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic uses_rt);
      return (d != 5'd0) && ((d == rs) || (uses_rt && (d == rt)));
   endfunction

   assign lu_stall = idex_memrd && dep_match(idex_rd, ifid_rs, ifid_rt, ifid_uses_rt);
   assign br_stall = ifid_is_branch &&
                     ((idex_regwr  && dep_match(idex_rd,  ifid_rs, ifid_rt, ifid_uses_rt)) ||
                      (exmem_memrd && dep_match(exmem_rd, ifid_rs, ifid_rt, ifid_uses_rt)));
   assign md_stall = ifid_is_md && (state == MD_BUSY);
   assign stall    = lu_stall || br_stall || md_stall;

   assign pc_we      = !stall;
   assign ifid_we    = !stall;
   assign idex_flush = stall;
   // A stalled branch has not resolved yet, so its redirect must not squash.
   assign ifid_flush = (branch_taken || jump) && !stall;

   assign md_busy = (state == MD_BUSY);
   assign md_done = (state == MD_DONE);
   assign md_err  = (state == MD_BUSY) && ex_md_start;
   assign wd_hit  = stall && (run_cnt >= RUN_LAST);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= MD_IDLE;
         md_cnt <= '0;
      end else begin
         unique case (state)
            MD_IDLE: if (ex_md_start) begin
               state  <= MD_BUSY;
               md_cnt <= MD_RELOAD;
            end
            MD_BUSY: if (md_cnt == '0) state <= MD_DONE;
                     else md_cnt <= md_cnt - MD_CW'(1);
            MD_DONE: if (ex_md_start) begin
               state  <= MD_BUSY;
               md_cnt <= MD_RELOAD;
            end else begin
               state  <= MD_IDLE;
            end
            default: state <= MD_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_cnt    <= '0;
         hazard_err <= 1'b0;
      end else begin
         if (!stall)                 run_cnt <= '0;
         else if (run_cnt != RUN_MAX) run_cnt <= run_cnt + RUN_CW'(1);
         if (md_err || wd_hit)       hazard_err <= 1'b1;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [15:0] perf_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              perf_cnt <= '0;
      else if (stall && (perf_cnt != 16'hFFFF)) perf_cnt <= perf_cnt + 16'd1;
   end

   assign stall_cnt = perf_cnt;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: load-use, branch, mult/div sequencing,
// watchdog and async reset, with hand-computed control vectors.
module tb_hazard_stall_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  ifid_rs, ifid_rt, idex_rd, exmem_rd;
   logic        ifid_uses_rt, ifid_is_branch, ifid_is_md;
   logic        idex_regwr, idex_memrd, exmem_memrd;
   logic        ex_md_start, branch_taken, jump;
   logic        pc_we, ifid_we, idex_flush, ifid_flush, md_busy, md_done, hazard_err;
   logic [15:0] stall_cnt;
   logic [6:0]  ctl;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef HAZARD_PERF_EN
   localparam int PERF = 1;
`else
   localparam int PERF = 0;
`endif

   // ctl = {pc_we, ifid_we, idex_flush, ifid_flush, md_busy, md_done, hazard_err}
   localparam logic [6:0] RUN = 7'b1100000;
   localparam logic [6:0] STL = 7'b0010000;
   localparam logic [6:0] RED = 7'b1101000;

   hazard_stall_ctrl #(.MD_LATENCY(4), .STALL_MAX(15)) dut (
      .clk(clk), .rst_n(rst_n),
      .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
      .ifid_is_branch(ifid_is_branch), .ifid_is_md(ifid_is_md),
      .idex_rd(idex_rd), .idex_regwr(idex_regwr), .idex_memrd(idex_memrd),
      .exmem_rd(exmem_rd), .exmem_memrd(exmem_memrd),
      .ex_md_start(ex_md_start), .branch_taken(branch_taken), .jump(jump),
      .pc_we(pc_we), .ifid_we(ifid_we), .idex_flush(idex_flush), .ifid_flush(ifid_flush),
      .md_busy(md_busy), .md_done(md_done), .hazard_err(hazard_err), .stall_cnt(stall_cnt)
   );

   assign ctl = {pc_we, ifid_we, idex_flush, ifid_flush, md_busy, md_done, hazard_err};

   always #5 clk = ~clk;

   task automatic clear_inputs;
      ifid_rs = 5'd0; ifid_rt = 5'd0; idex_rd = 5'd0; exmem_rd = 5'd0;
      ifid_uses_rt = 1'b0; ifid_is_branch = 1'b0; ifid_is_md = 1'b0;
      idex_regwr = 1'b0; idex_memrd = 1'b0; exmem_memrd = 1'b0;
      ex_md_start = 1'b0; branch_taken = 1'b0; jump = 1'b0;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      clear_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset;
      clear_inputs();
      rst_n = 1'b0;
      #2;
      n_tests++;
      if (ctl !== RUN) begin
         n_fail++; $display("FAIL reset_ctl: got %b expected %b", ctl, RUN);
      end
      n_tests++;
      if (stall_cnt !== 16'd0) begin
         n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
      end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_load_use;
      do_reset();
      // lw r5 in EX, consumer reads rs=5
      idex_memrd = 1'b1; idex_regwr = 1'b1; idex_rd = 5'd5; ifid_rs = 5'd5;
      #1;
      n_tests++;
      if (ctl !== STL) begin
         n_fail++; $display("FAIL load_use_stall: got %b expected %b", ctl, STL);
      end
      tick();
      // load advanced to MEM, bubble in EX
      idex_memrd = 1'b0; idex_regwr = 1'b0; idex_rd = 5'd0;
      exmem_memrd = 1'b1; exmem_rd = 5'd5;
      #1;
      n_tests++;
      if (ctl !== RUN) begin
         n_fail++; $display("FAIL load_use_release: got %b expected %b", ctl, RUN);
      end
      n_tests++;
      if (stall_cnt !== 16'(PERF)) begin
         n_fail++; $display("FAIL load_use_stall_cnt: got %0d expected %0d", stall_cnt, PERF);
      end
      tick();
      // rt dependency only counts when the instruction reads rt
      clear_inputs();
      idex_memrd = 1'b1; idex_rd = 5'd12; ifid_rs = 5'd7; ifid_rt = 5'd12; ifid_uses_rt = 1'b1;
      #1;
      n_tests++;
      if (ctl !== STL) begin
         n_fail++; $display("FAIL load_use_rt: got %b expected %b", ctl, STL);
      end
      ifid_uses_rt = 1'b0;
      #1;
      n_tests++;
      if (ctl !== RUN) begin
         n_fail++; $display("FAIL load_use_rt_unused: got %b expected %b", ctl, RUN);
      end
      // a plain ALU producer in EX forwards: no stall for a non-branch
      idex_memrd = 1'b0; idex_regwr = 1'b1; ifid_uses_rt = 1'b1;
      #1;
      n_tests++;
      if (ctl !== RUN) begin
         n_fail++; $display("FAIL alu_no_stall: got %b expected %b", ctl, RUN);
      end
      tick();
   endtask

   task automatic test_zero_reg;
      do_reset();
      idex_memrd = 1'b1; idex_rd = 5'd0; ifid_rs = 5'd0; ifid_uses_rt = 1'b1; ifid_rt = 5'd0;
      #1;
      n_tests++;
      if (ctl !== RUN) begin
         n_fail++; $display("FAIL zero_reg: got %b expected %b", ctl, RUN);
      end
      // real load-use with a redirect request: redirect ignored
      idex_rd = 5'd4; ifid_rs = 5'd4; branch_taken = 1'b1;
      #1;
      n_tests++;
      if (ctl !== STL) begin
         n_fail++; $display("FAIL redirect_during_stall: got %b expected %b", ctl, STL);
      end
      tick();
   endtask

   task automatic test_branch;
      do_reset();
      // beq rs=3 in ID, lw r3 in EX
      ifid_is_branch = 1'b1; ifid_rs = 5'd3; ifid_rt = 5'd8; ifid_uses_rt = 1'b1;
      idex_memrd = 1'b1; idex_regwr = 1'b1; idex_rd = 5'd3;
      #1;
      n_tests++;
      if (ctl !== STL) begin
         n_fail++; $display("FAIL branch_load_ex: got %b expected %b", ctl, STL);
      end
      tick();
      // load now in MEM; branch still waiting, its redirect is not yet valid
      idex_memrd = 1'b0; idex_regwr = 1'b0; idex_rd = 5'd0;
      exmem_memrd = 1'b1; exmem_rd = 5'd3; branch_taken = 1'b1;
      #1;
      n_tests++;
      if (ctl !== STL) begin
         n_fail++; $display("FAIL branch_load_mem: got %b expected %b", ctl, STL);
      end
      tick();
      exmem_memrd = 1'b0; exmem_rd = 5'd0;
      #1;
      n_tests++;
      if (ctl !== RED) begin
         n_fail++; $display("FAIL branch_redirect: got %b expected %b", ctl, RED);
      end
      n_tests++;
      if (stall_cnt !== 16'(2 * PERF)) begin
         n_fail++; $display("FAIL branch_stall_cnt: got %0d expected %0d", stall_cnt, 2 * PERF);
      end
      tick();
      // ALU result for rt=8 in EX must stall a branch (compare happens in ID)
      branch_taken = 1'b0; idex_regwr = 1'b1; idex_rd = 5'd8;
      #1;
      n_tests++;
      if (ctl !== STL) begin
         n_fail++; $display("FAIL branch_alu_ex: got %b expected %b", ctl, STL);
      end
      // non-load in MEM forwards
      idex_regwr = 1'b0; idex_rd = 5'd0; exmem_rd = 5'd8; exmem_memrd = 1'b0;
      #1;
      n_tests++;
      if (ctl !== RUN) begin
         n_fail++; $display("FAIL branch_alu_mem: got %b expected %b", ctl, RUN);
      end
      ifid_is_branch = 1'b0; jump = 1'b1;
      #1;
      n_tests++;
      if (ctl !== RED) begin
         n_fail++; $display("FAIL jump_redirect: got %b expected %b", ctl, RED);
      end
      tick();
   endtask

   task automatic test_md;
      do_reset();
      ifid_is_md = 1'b1; ex_md_start = 1'b1;
      #1;
      n_tests++;
      if (ctl !== RUN) begin
         n_fail++; $display("FAIL md_issue: got %b expected %b", ctl, RUN);
      end
      tick();
      ex_md_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (ctl !== 7'b0010100) begin
            n_fail++; $display("FAIL md_busy_c%0d: got %b expected %b", i, ctl, 7'b0010100);
         end
         tick();
      end
      n_tests++;
      if (ctl !== 7'b1100010) begin
         n_fail++; $display("FAIL md_done: got %b expected %b", ctl, 7'b1100010);
      end
      tick();
      n_tests++;
      if (ctl !== RUN) begin
         n_fail++; $display("FAIL md_idle: got %b expected %b", ctl, RUN);
      end
   endtask

   task automatic test_back_to_back;
      do_reset();
      ex_md_start = 1'b1;
      tick();
      ex_md_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (ctl !== 7'b1100100) begin
            n_fail++; $display("FAIL b2b_busy_c%0d: got %b expected %b", i, ctl, 7'b1100100);
         end
         tick();
      end
      ex_md_start = 1'b1;
      #1;
      n_tests++;
      if (ctl !== 7'b1100010) begin
         n_fail++; $display("FAIL b2b_done_start: got %b expected %b", ctl, 7'b1100010);
      end
      tick();
      // start again while busy: flagged, ignored
      n_tests++;
      if (ctl !== 7'b1100100) begin
         n_fail++; $display("FAIL b2b_reload: got %b expected %b", ctl, 7'b1100100);
      end
      tick();
      ex_md_start = 1'b0;
      for (int i = 1; i < 4; i++) begin
         n_tests++;
         if (ctl !== 7'b1100101) begin
            n_fail++; $display("FAIL busy_start_c%0d: got %b expected %b", i, ctl, 7'b1100101);
         end
         tick();
      end
      n_tests++;
      if (ctl !== 7'b1100011) begin
         n_fail++; $display("FAIL busy_start_done: got %b expected %b", ctl, 7'b1100011);
      end
      tick();
      n_tests++;
      if (ctl !== 7'b1100001) begin
         n_fail++; $display("FAIL busy_start_idle: got %b expected %b", ctl, 7'b1100001);
      end
   endtask

   task automatic test_watchdog;
      do_reset();
      idex_memrd = 1'b1; idex_rd = 5'd9; ifid_rs = 5'd9;
      for (int i = 1; i <= 15; i++) begin
         #1;
         n_tests++;
         if (ctl !== STL || stall_cnt !== 16'((i - 1) * PERF)) begin
            n_fail++;
            $display("FAIL wd_c%0d: got ctl=%b cnt=%0d expected ctl=%b cnt=%0d",
                     i, ctl, stall_cnt, STL, (i - 1) * PERF);
         end
         tick();
      end
      n_tests++;
      if (ctl !== 7'b0010001) begin
         n_fail++; $display("FAIL wd_err: got %b expected %b", ctl, 7'b0010001);
      end
      n_tests++;
      if (stall_cnt !== 16'(15 * PERF)) begin
         n_fail++; $display("FAIL wd_stall_cnt: got %0d expected %0d", stall_cnt, 15 * PERF);
      end
      clear_inputs();
      tick();
      n_tests++;
      if (ctl !== 7'b1100001 || stall_cnt !== 16'(15 * PERF)) begin
         n_fail++;
         $display("FAIL wd_sticky: got ctl=%b cnt=%0d expected ctl=%b cnt=%0d",
                  ctl, stall_cnt, 7'b1100001, 15 * PERF);
      end
      // async reset in the middle of a mult/div
      ex_md_start = 1'b1;
      tick();
      ex_md_start = 1'b0;
      tick();
      n_tests++;
      if (ctl !== 7'b1100101) begin
         n_fail++; $display("FAIL pre_reset_busy: got %b expected %b", ctl, 7'b1100101);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (ctl !== RUN || stall_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL async_reset: got ctl=%b cnt=%0d expected ctl=%b cnt=0", ctl, stall_cnt, RUN);
      end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      test_reset();
      test_load_use();
      test_zero_reg();
      test_branch();
      test_md();
      test_back_to_back();
      test_watchdog();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
